beat_sequencer: RTL and testbench

//  Single-clock beat sequencer that drives the song-ROM beat index for the tone path.

---
 rtl/music_pkg.sv | 19 +
 rtl/beat_tick_gen.sv | 42 ++++
 rtl/beat_sequencer.sv | 110 +++++++++++
 tb/tb_beat_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/music_pkg.sv
// Shared definitions for the music playback path: sequencer state encoding,
// beat divider computation and the default beat-index width.
package music_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

  localparam int DEFAULT_BEAT_W = 8;

  // Clock cycles per beat; integer division, remainder is dropped.
  function automatic int beat_div(input int clk_freq, input int beat_freq);
    return clk_freq / beat_freq;
  endfunction

endpackage

// File: rtl/beat_tick_gen.sv
// Beat divider: counts 0..DIV-1 while run is high, holds otherwise, and
// clears on demand. Emits a registered one-cycle tick on each wrap and a
// gate_open flag that drops for the last GAP_CYCLES counts of every beat.
// GAP_CYCLES must be smaller than DIV.
module beat_tick_gen #(
  parameter int DIV        = 10,
  parameter int GAP_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic wrap,
  output logic tick,
  output logic gate_open
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] OPEN_LIM = CNT_W'(DIV - GAP_CYCLES);

  logic [CNT_W-1:0] div_cnt;

  // wrap marks the final count of a beat; the tick itself is taken only when running
  assign wrap      = (div_cnt == LAST);
  assign gate_open = (div_cnt < OPEN_LIM);

  // divider counter and registered tick; clear beats run so entry to IDLE/DONE lands at 0
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      tick <= run && wrap;
      if (clear)
        div_cnt <= '0;
      else if (run)
        div_cnt <= wrap ? '0 : div_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/beat_sequencer.sv
// Beat sequencer: drives the song-ROM beat index from a clock-enable beat
// tick, with play/pause/stop/loop control and a per-beat note gate so that
// repeated notes articulate. Control priority each cycle is
// reset > stop > pause > play.
module beat_sequencer
  import music_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BEAT_FREQ  = 8,
  parameter int GAP_CYCLES = 1_000_000,
  parameter int BEAT_W     = DEFAULT_BEAT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play,
  input  logic              pause,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [BEAT_W-1:0] song_len,
  output logic [BEAT_W-1:0] ibeat,
  output logic              beat_tick,
  output logic              note_gate,
  output logic              playing,
  output logic              done
);

  localparam int DIV = beat_div(CLK_FREQ, BEAT_FREQ);

  seq_state_t        state_q, state_d;
  logic [BEAT_W-1:0] len_q;
  logic [BEAT_W:0]   ibeat_p1;
  logic              run, start, clear, wrap, gate_open, last_beat, tick_now;

  // one bit wider so the end-of-song compare cannot overflow at the top index
  assign ibeat_p1  = {1'b0, ibeat} + {{BEAT_W{1'b0}}, 1'b1};
  assign last_beat = (ibeat_p1 >= {1'b0, len_q});

  // state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // next state, divider run enable and song start strobe
  always_comb begin
    state_d = state_q;
    run     = 1'b0;
    start   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (stop) state_d = ST_IDLE;
        else if (!pause && play && song_len != '0) begin
          state_d = ST_PLAY;
          start   = 1'b1;
        end
      end
      ST_PLAY: begin
        if (stop)       state_d = ST_IDLE;
        else if (pause) state_d = ST_PAUSE;
        else begin
          run = 1'b1;
          if (wrap && last_beat && !loop_en) state_d = ST_DONE;
        end
      end
      ST_PAUSE: begin
        if (stop)                state_d = ST_IDLE;
        else if (play && !pause) state_d = ST_PLAY;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign tick_now = run && wrap;
  // the divider rests at 0 in IDLE/DONE and restarts from 0 on a new song
  assign clear    = (state_d == ST_IDLE) || (state_d == ST_DONE) || start;

  beat_tick_gen #(
    .DIV        (DIV),
    .GAP_CYCLES (GAP_CYCLES)
  ) u_tick (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .clear     (clear),
    .wrap      (wrap),
    .tick      (beat_tick),
    .gate_open (gate_open)
  );

  // beat index and latched song length; ibeat holds on the final beat when entering DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      ibeat <= '0;
      len_q <= '0;
    end else if (state_d == ST_IDLE) begin
      ibeat <= '0;
    end else if (start) begin
      ibeat <= '0;
      len_q <= song_len;
    end else if (tick_now) begin
      if (!last_beat)   ibeat <= ibeat_p1[BEAT_W-1:0];
      else if (loop_en) ibeat <= '0;
    end
  end

  assign playing   = (state_q == ST_PLAY);
  assign done      = (state_q == ST_DONE);
  assign note_gate = playing && gate_open;

endmodule

// File: tb/tb_beat_sequencer.sv
// Directed bench for beat_sequencer with DIV=10, GAP_CYCLES=2.
module tb_beat_sequencer;

  logic       clk = 1'b0;
  logic       reset, play, pause, stop, loop_en;
  logic [7:0] song_len;
  logic [7:0] ibeat;
  logic       beat_tick, note_gate, playing, done;

  int checks   = 0;
  int failures = 0;

  beat_sequencer #(
    .CLK_FREQ   (100),
    .BEAT_FREQ  (10),
    .GAP_CYCLES (2),
    .BEAT_W     (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .play      (play),
    .pause     (pause),
    .stop      (stop),
    .loop_en   (loop_en),
    .song_len  (song_len),
    .ibeat     (ibeat),
    .beat_tick (beat_tick),
    .note_gate (note_gate),
    .playing   (playing),
    .done      (done)
  );

  always #5 clk = ~clk;

  // advance n rising edges, then settle 1 time unit before sampling/driving
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk8({tag, "_ibeat"}, ibeat, 8'd0);
    chk1({tag, "_tick"}, beat_tick, 1'b0);
    chk1({tag, "_gate"}, note_gate, 1'b0);
    chk1({tag, "_playing"}, playing, 1'b0);
    chk1({tag, "_done"}, done, 1'b0);
  endtask

  initial begin
    int gate_hi;
    int n;
    reset = 1'b1; play = 1'b0; pause = 1'b0; stop = 1'b0;
    loop_en = 1'b0; song_len = 8'd0;

    // reset state
    step(2);
    chk_all_zero("reset");
    reset = 1'b0;

    // 1: four-beat song, no loop
    play = 1'b1; song_len = 8'd4;
    step(1);
    chk1("t1_playing", playing, 1'b1);
    chk8("t1_ibeat0", ibeat, 8'd0);
    chk1("t1_gate0", note_gate, 1'b1);
    play = 1'b0;
    gate_hi = 0;
    for (int k = 1; k <= 40; k++) begin
      step(1);
      chk1("t1_tick", beat_tick, (k % 10) == 0);
      if (k <= 30 && note_gate) gate_hi++;
      if (k == 10) chk8("t1_ibeat1", ibeat, 8'd1);
      if (k == 20) chk8("t1_ibeat2", ibeat, 8'd2);
      if (k == 30) chk8("t1_ibeat3", ibeat, 8'd3);
    end
    chki("t1_gate_duty", gate_hi, 24);
    chk1("t1_done", done, 1'b1);
    chk1("t1_not_playing", playing, 1'b0);
    chk8("t1_ibeat_end", ibeat, 8'd3);
    chk1("t1_gate_done", note_gate, 1'b0);
    step(1);
    chk1("t1_tick_once", beat_tick, 1'b0);
    chk1("t1_done_hold", done, 1'b1);

    // 5b: restart from DONE with a two-beat song
    song_len = 8'd2; play = 1'b1;
    step(1);
    chk1("t5_restart_playing", playing, 1'b1);
    chk1("t5_restart_done", done, 1'b0);
    chk8("t5_restart_ibeat", ibeat, 8'd0);
    play = 1'b0;
    step(10);
    chk1("t5_tick1", beat_tick, 1'b1);
    chk8("t5_ibeat1", ibeat, 8'd1);
    step(10);
    chk1("t5_tick2", beat_tick, 1'b1);
    chk8("t5_ibeat_hold", ibeat, 8'd1);
    chk1("t5_done", done, 1'b1);

    // stop from DONE
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    chk1("done_stop", done, 1'b0);
    chk8("done_stop_ibeat", ibeat, 8'd0);

    // 5a: zero-length song is ignored
    play = 1'b1; song_len = 8'd0;
    step(2);
    chk1("t5_len0_playing", playing, 1'b0);
    chk1("t5_len0_gate", note_gate, 1'b0);

    // 2: looping, play held high throughout
    loop_en = 1'b1; song_len = 8'd4;
    step(1);
    chk1("t2_playing", playing, 1'b1);
    for (int k = 1; k <= 60; k++) begin
      step(1);
      chk1("t2_tick", beat_tick, (k % 10) == 0);
      chk1("t2_no_done", done, 1'b0);
      if ((k % 10) == 0) chk8("t2_ibeat", ibeat, 8'((k / 10) % 4));
    end

    // 3: pause 25 cycles at div_cnt=5 of beat 2
    step(5);
    pause = 1'b1;
    step(1);
    chk1("t3_paused", playing, 1'b0);
    for (int k = 0; k < 24; k++) begin
      step(1);
      chk1("t3_pause_tick", beat_tick, 1'b0);
      chk1("t3_pause_gate", note_gate, 1'b0);
    end
    chk8("t3_pause_ibeat", ibeat, 8'd2);
    pause = 1'b0;
    step(1);
    chk1("t3_resumed", playing, 1'b1);
    chk1("t3_resume_gate", note_gate, 1'b1);
    n = 0;
    while (n < 20 && !beat_tick) begin
      step(1);
      n++;
    end
    chki("t3_cycles_to_tick", n, 5);
    chk8("t3_ibeat_after", ibeat, 8'd3);

    // 4: stop and pause together during PLAY
    step(3);
    stop = 1'b1; pause = 1'b1;
    step(1);
    stop = 1'b0; pause = 1'b0; play = 1'b0;
    chk_all_zero("t4");

    // single-beat looping song: index stays 0, ticks keep coming
    song_len = 8'd1; play = 1'b1;
    step(1);
    play = 1'b0;
    step(10);
    chk1("len1_tick1", beat_tick, 1'b1);
    chk8("len1_ibeat1", ibeat, 8'd0);
    step(10);
    chk1("len1_tick2", beat_tick, 1'b1);
    chk1("len1_playing", playing, 1'b1);
    stop = 1'b1;
    step(1);
    stop = 1'b0;

    // 6: reset on the cycle a tick would otherwise fire
    loop_en = 1'b0; song_len = 8'd4; play = 1'b1;
    step(1);
    play = 1'b0;
    step(10);
    chk8("t6_ibeat1", ibeat, 8'd1);
    step(9);
    reset = 1'b1;
    step(1);
    chk_all_zero("t6_reset");
    reset = 1'b0;
    step(2);
    chk_all_zero("t6_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // overall time limit
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
